// File: rtl/pixel_frame_sched_if.sv
// Memory read port and pixel stream bundle for the frame scheduler.
// Pixel stream: a transfer happens on a rising edge where pix_valid && pix_ready;
// while pix_valid=1 and pix_ready=0 the producer holds pix_data and markers stable,
// and pix_valid is never withdrawn except by abort or reset.
interface pixel_frame_sched_if #(
  parameter int AW = 10
);
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;

  // Scheduler side
  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  // Image memory and downstream consumer side
  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/pixel_frame_sched.sv
// Frame scheduler: issues image-memory reads for NPIX pixels per frame, runs a
// requested number of frames with an idle gap between them, and streams the
// pixels with sof/eol/eof markers through a 2-entry output FIFO.
module pixel_frame_sched #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int AW      = 10,
  parameter int GAP_CYC = 4,
  parameter int FW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FW-1:0]     num_frames,
  input  logic              abort,
  pixel_frame_sched_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [FW-1:0]     frame_idx,
  output logic [1:0]        dbg_state
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] frames_q, frames_d;
  logic [FW-1:0] fidx_q, fidx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic          infl_q, infl_d;     // a read was issued last cycle; data is on mem_rdata now
  logic [2:0]    mk_q, mk_d;         // {sof, eol, eof} travelling with the in-flight read
  logic [10:0]   e0_q, e0_d;         // FIFO head {data, sof, eol, eof}
  logic [10:0]   e1_q, e1_d;         // FIFO second entry
  logic [1:0]    cnt_q, cnt_d;       // FIFO occupancy 0..2

  logic          pop;
  logic          push;
  logic          rd_en;
  logic [2:0]    occ;
  logic          last_addr;
  logic [10:0]   wr_ent;
  logic [2:0]    mk_now;

  // Handshake, read-issue throttle and marker decode for the current address
  always_comb begin
    pop       = (cnt_q != 2'd0) && bus.pix_ready;
    push      = infl_q;
    occ       = {1'b0, cnt_q} + {2'b00, infl_q};
    rd_en     = (state_q == S_RUN) && (occ < (3'd2 + {2'b00, pop}));
    last_addr = (addr_q == AW'(NPIX - 1));
    mk_now    = {(row_q == '0) && (col_q == '0), col_q == CW'(IMG_W - 1), last_addr};
    wr_ent    = {bus.mem_rdata, mk_q};
  end

  // Next-state: frame sequencing, address/row/col counters, FIFO, abort flush
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    col_d    = col_q;
    row_d    = row_q;
    frames_d = frames_q;
    fidx_d   = fidx_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    infl_d   = rd_en;
    mk_d     = rd_en ? mk_now : mk_q;
    e0_d     = e0_q;
    e1_d     = e1_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          frames_d = (num_frames == '0) ? FW'(1) : num_frames;
          fidx_d   = '0;
          addr_d   = '0;
          col_d    = '0;
          row_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_addr) begin
            addr_d  = '0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Empty FIFO with nothing in flight means the eof pixel has transferred
        if ((cnt_q == 2'd0) && !infl_q) begin
          if (fidx_q != (frames_q - FW'(1))) begin
            fidx_d  = fidx_q + FW'(1);
            gap_d   = '0;
            state_d = (GAP_CYC == 0) ? S_RUN : S_GAP;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          addr_d  = '0;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = wr_ent;
        else               e1_d = wr_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = wr_ent;
        end else begin
          e0_d = wr_ent;
        end
      end
      default: ;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      col_d   = '0;
      row_d   = '0;
      gap_d   = '0;
      done_d  = 1'b0;
      infl_d  = 1'b0;
      mk_d    = '0;
      e0_d    = '0;
      e1_d    = '0;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      frames_q <= '0;
      fidx_q   <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      infl_q   <= 1'b0;
      mk_q     <= '0;
      e0_q     <= '0;
      e1_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      frames_q <= frames_d;
      fidx_q   <= fidx_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      infl_q   <= infl_d;
      mk_q     <= mk_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    bus.mem_rd_en = rd_en;
    bus.mem_addr  = addr_q;
    bus.pix_valid = (cnt_q != 2'd0);
    bus.pix_data  = e0_q[10:3];
    bus.pix_sof   = e0_q[2];
    bus.pix_eol   = e0_q[1];
    bus.pix_eof   = e0_q[0];
    busy          = (state_q != S_IDLE);
    done          = done_q;
    frame_idx     = fidx_q;
    dbg_state     = state_q;
  end

  // The read throttle guarantees a push never lands on a full FIFO without a pop
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (cnt_q != 2'd2));

endmodule

// File: doc/pixel_frame_sched.md
Name: pixel_frame_sched

Overview:
- Sequences image-memory reads and streams NPIX pixels per frame to the CNN input stage over a valid/ready interface.
- Runs a host-requested number of frames back to back, with a programmable idle gap between frames.
- Attaches start-of-frame, end-of-line and end-of-frame markers to each pixel.
- Sits between the pixel image memory (1-cycle synchronous read) and the first convolution layer's line buffers.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame; NPIX = IMG_W*IMG_H.
- AW, 10, memory address width; must satisfy 2^AW >= NPIX.
- GAP_CYC, 4, idle cycles between consecutive frames; 0 is legal and means no gap.
- FW, 8, frame-count width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_frames  in  FW  frames to run; latched on an accepted start; 0 is treated as 1.
- abort  in  1  synchronous stop; flushes everything and returns to IDLE.
- mem_rd_en  out  1  read strobe to the image memory.
- mem_addr  out  AW  read address; mem_rdata is valid the cycle after mem_rd_en.
- mem_rdata  in  8  memory read data.
- pix_data  out  8  pixel to downstream.
- pix_valid  out  1  pix_data and the markers are valid.
- pix_ready  in  1  downstream accept; a transfer occurs when pix_valid && pix_ready.
- pix_sof  out  1  first pixel of a frame (row 0, col 0).
- pix_eol  out  1  last pixel of a row (col IMG_W-1).
- pix_eof  out  1  last pixel of a frame (address NPIX-1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last frame's eof transfer.
- frame_idx  out  FW  index of the frame currently being issued, counting from 0.

Behaviour:
- Reset: with rst=1 at a clock edge, the block enters IDLE next cycle.
  - Reset values: all outputs 0, FIFO empty, in-flight flag cleared, address, row, col and frame counters 0.
  - Reset has priority over abort and start.
- States:
  - IDLE: start=1 latches max(num_frames,1) and goes to RUN; frame_idx=0.
  - RUN: issues reads at addresses 0..NPIX-1. After issuing address NPIX-1 it goes to DRAIN.
  - DRAIN: no reads. Waits until the FIFO is empty, nothing is in flight, and the eof pixel has transferred.
    - More frames remain: go to GAP, or to RUN directly when GAP_CYC=0; frame_idx increments.
    - Last frame: go to IDLE and pulse done in that same cycle.
  - GAP: counts GAP_CYC cycles, then goes to RUN with address reset to 0.
- Read issue: the output buffer is a 2-entry FIFO holding {data, sof, eol, eof}.
  - In RUN, mem_rd_en=1 when count + inflight - pop < 2, where pop = pix_valid && pix_ready this cycle.
  - This sustains 1 pixel/cycle while pix_ready is held high.
  - Markers are computed from the issued address's row/col counters and are pipelined one cycle alongside the read.
- Latency: start in cycle 0 puts mem_rd_en high in cycle 1; the first pix_valid with sof appears in cycle 3.
  - Cycle 3 comes from: read data in cycle 2, FIFO write, registered output.
- Output stage:
  - pix_valid = FIFO not empty.
  - pix_data and the markers come from the FIFO head.
  - While pix_valid=1 and pix_ready=0, pix_data and all markers must remain stable.
  - Overflow is impossible by construction; a write into a full FIFO is an assertion failure.
- Counters: col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0 at end of frame. No address wrap occurs inside a frame.
- Abort: takes effect in any state.
  - Next cycle: IDLE, FIFO flushed, in-flight read data discarded, pix_valid=0.
  - done is not pulsed. A start asserted in the same cycle as abort is ignored.
- start while busy is ignored. num_frames changes while busy have no effect.
- Simultaneous FIFO push and pop is allowed at any occupancy, including a single-entry FIFO.

Test Plan:
- Single frame: num_frames=1, pix_ready=1. Expect exactly 784 transfers, data equal to memory contents for addresses 0..783. sof only on transfer 0; eol on transfers 27, 55, ..., 783 (28 total); eof on 783. done pulses once; busy falls the same cycle.
- Back-to-back frames: num_frames=3, GAP_CYC=4. Expect 2352 transfers, 3 sof/eof pairs, at least 4 idle cycles between each eof and the next sof, frame_idx stepping 0, 1, 2, one done pulse.
- Backpressure: toggle pix_ready with a random 50% pattern. Verify no pixel is lost or duplicated, data and markers are stable while stalled, and mem_rd_en never fires with count + inflight - pop = 2.
- Abort: abort at transfer 400 of frame 0 of 2. Expect pix_valid=0 the next cycle, state IDLE, no done pulse. A new start then begins cleanly with sof at address 0.
- Reset mid-frame: rst at transfer 100. Expect all outputs 0 next cycle and correct operation on the next start.
- Corner cases: num_frames=0 runs one frame. start pulsed while busy is ignored. pix_ready held low for 50 cycles right after sof: expect the first pixel held and exactly 2 reads issued.
